// File: rtl/peridot_swi_mc_pkg.sv
// Shared constants for the PERIDOT multi-channel software-interrupt block.
// Register addresses, deadkey and CTRL bit positions.
package peridot_swi_mc_pkg;

    localparam logic [3:0] ADDR_CLASS   = 4'd0;
    localparam logic [3:0] ADDR_TIME    = 4'd1;
    localparam logic [3:0] ADDR_CTRL    = 4'd2;
    localparam logic [3:0] ADDR_MUTEX   = 4'd3;
    localparam logic [3:0] ADDR_PENDING = 4'd4;
    localparam logic [3:0] ADDR_SET     = 4'd5;
    localparam logic [3:0] ADDR_CLEAR   = 4'd6;
    localparam logic [3:0] ADDR_ENABLE  = 4'd7;
    localparam logic [3:0] ADDR_MESSAGE = 4'd8;

    localparam logic [15:0] DEADKEY = 16'hDEAD;

    localparam int CTRL_RESET = 0;
    localparam int CTRL_LED   = 1;
    localparam int CTRL_PULSE = 2;

endpackage

// File: rtl/peridot_swi_edge.sv
// Two-flop synchronizer plus rising-edge detector for one event input.
// The rise output is combinational from the last two stages.
module peridot_swi_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/peridot_swi_mc.sv
// PERIDOT multi-channel software interrupt sender with mutex, mailbox
// and deadkey-guarded CPU reset (level or self-timed pulse).
module peridot_swi_mc
    import peridot_swi_mc_pkg::*;
#(
    parameter logic [31:0] CLASSID    = 32'h72A00001,
    parameter logic [31:0] TIMECODE   = 32'd1234567890,
    parameter int          CHANNELS   = 8,
    parameter int          RESET_HOLD = 1024
) (
    input  logic                csi_clk,
    input  logic                rsi_reset_n,
    input  logic [3:0]          avs_address,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic                ins_irq,
    input  logic [CHANNELS-1:0] coe_swi_in,
    output logic                coe_cpureset,
    output logic                coe_led
);

    logic                ctrl_rst;
    logic                ctrl_led;
    logic                ctrl_pulse;
    logic [15:0]         cnt;
    logic [15:0]         mtx_owner;
    logic [15:0]         mtx_value;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] enable;
    logic [31:0]         message;
    logic                irq;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] set_mask;
    logic [CHANNELS-1:0] clr_mask;
    logic                key;
    logic                mtx_ok;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_edge
        peridot_swi_edge u_edge (
            .clk   (csi_clk),
            .rst_n (rsi_reset_n),
            .din   (coe_swi_in[i]),
            .rise  (rise[i])
        );
    end

    assign key    = (avs_writedata[31:16] == DEADKEY);
    assign mtx_ok = (mtx_value == 16'd0) ||
                    (mtx_owner == avs_writedata[31:16]);

    assign set_mask = (avs_write && avs_address == ADDR_SET) ?
                      avs_writedata[CHANNELS-1:0] : '0;
    assign clr_mask = (avs_write && avs_address == ADDR_CLEAR) ?
                      avs_writedata[CHANNELS-1:0] : '0;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            ctrl_rst   <= 1'b0;
            ctrl_led   <= 1'b0;
            ctrl_pulse <= 1'b0;
            cnt        <= 16'd0;
            mtx_owner  <= 16'd0;
            mtx_value  <= 16'd0;
            pending    <= '0;
            enable     <= '0;
            message    <= 32'd0;
            irq        <= 1'b0;
        end else begin
            irq     <= |(pending & enable);
            // Events and SET override a same-cycle CLEAR
            pending <= (pending & ~clr_mask) | set_mask | rise;

            if (avs_write && avs_address == ADDR_CTRL) begin
                ctrl_led <= avs_writedata[CTRL_LED];
                if (key) begin
                    ctrl_rst   <= avs_writedata[CTRL_RESET];
                    ctrl_pulse <= avs_writedata[CTRL_PULSE];
                    cnt        <= (avs_writedata[CTRL_RESET] &&
                                   avs_writedata[CTRL_PULSE]) ?
                                  16'(RESET_HOLD) : 16'd0;
                end
            end else if (ctrl_pulse && ctrl_rst && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
                if (cnt == 16'd1) ctrl_rst <= 1'b0;
            end

            if (avs_write && avs_address == ADDR_MUTEX && mtx_ok) begin
                if (avs_writedata[15:0] == 16'd0) begin
                    mtx_owner <= 16'd0;
                    mtx_value <= 16'd0;
                end else begin
                    mtx_owner <= avs_writedata[31:16];
                    mtx_value <= avs_writedata[15:0];
                end
            end

            if (avs_write && avs_address == ADDR_ENABLE)
                enable <= avs_writedata[CHANNELS-1:0];
            if (avs_write && avs_address == ADDR_MESSAGE)
                message <= avs_writedata;
        end
    end

    always_comb begin
        avs_readdata = 32'd0;
        if (avs_read) begin
            case (avs_address)
                ADDR_CLASS:   avs_readdata = CLASSID;
                ADDR_TIME:    avs_readdata = TIMECODE;
                ADDR_CTRL:    avs_readdata = {29'd0, ctrl_pulse,
                                              ctrl_led, ctrl_rst};
                ADDR_MUTEX:   avs_readdata = {mtx_owner, mtx_value};
                ADDR_PENDING: avs_readdata[CHANNELS-1:0] = pending;
                ADDR_ENABLE:  avs_readdata[CHANNELS-1:0] = enable;
                ADDR_MESSAGE: avs_readdata = message;
                default:      avs_readdata = 32'd0;
            endcase
        end
    end

    assign ins_irq      = irq;
    assign coe_cpureset = ctrl_rst;
    assign coe_led      = ctrl_led;

endmodule
